// File: rtl/otter_io_pkg.sv
// Shared constants and types for the Otter MMIO UART transmitter.
package otter_io_pkg;

   localparam logic [31:0] TX_ADDR_DFLT   = 32'h1100_0040;
   localparam logic [31:0] STAT_ADDR_DFLT = 32'h1100_0044;

   // Bit positions inside the status word returned on IOBUS_IN
   localparam int STAT_FULL    = 0;
   localparam int STAT_OVF     = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_EMPTY   = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/iobus_uart_tx_if.sv
// Otter MMIO bus as seen between the CPU core (master) and a peripheral (slave).
interface iobus_uart_tx_if;

   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;

   modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
   modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);

endinterface

// File: rtl/iobus_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push to a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           dout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             wr_en, rd_en;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/iobus_uart_tx.sv
// MMIO UART transmitter: buffered byte writes serialized 8N1, LSB first, plus a
// status register with a sticky overflow flag.
module iobus_uart_tx
   import otter_io_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] TX_ADDR    = TX_ADDR_DFLT,
   parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DFLT
) (
   input  logic           CLK,
   input  logic           RST,
   iobus_uart_tx_if.slave bus,
   output logic           TXD,
   output logic           TX_BUSY
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   uart_tx_state_t state;
   logic [BW-1:0]  baud_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift;
   logic           ovf;

   logic           wr_tx, wr_stat, pop, baud_done;
   logic           fifo_full, fifo_empty;
   logic [AW:0]    fifo_cnt;
   logic [7:0]     fifo_head;
   logic [31:0]    cnt_ext, stat;
   logic [3:0]     cnt_sat;
   logic           unused_bits;

   assign wr_tx       = bus.IOBUS_WR && (bus.IOBUS_ADDR == TX_ADDR);
   assign wr_stat     = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_ADDR);
   assign unused_bits = ^bus.IOBUS_OUT[31:8];
   assign baud_done   = (baud_cnt == BAUD_LAST);
   // Pop from IDLE, or at the tail of STOP so frames run back to back
   assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (RST),
      .push  (wr_tx),
      .pop   (pop),
      .din   (bus.IOBUS_OUT[7:0]),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt),
      .dout  (fifo_head)
   );

   // Set beats clear; a drop only happens when no pop frees a slot
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                               ovf <= 1'b0;
      else if (wr_tx && fifo_full && !pop)    ovf <= 1'b1;
      else if (wr_stat && bus.IOBUS_OUT[1])   ovf <= 1'b0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shift <= fifo_head;
                  state <= START;
               end
            end
            START: begin
               baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
               if (baud_done) begin
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
               if (baud_done) begin
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            default: begin
               baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
               if (baud_done) begin
                  if (pop) begin
                     shift <= fifo_head;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      TXD = 1'b1;
      case (state)
         START:   TXD = 1'b0;
         DATA:    TXD = shift[0];
         default: TXD = 1'b1;
      endcase
   end

   assign TX_BUSY = (state != IDLE) || !fifo_empty;

   always_comb begin
      cnt_ext = 32'(fifo_cnt);
      cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
      stat = '0;
      stat[STAT_FULL]             = fifo_full;
      stat[STAT_OVF]              = ovf;
      stat[STAT_BUSY]             = TX_BUSY;
      stat[STAT_EMPTY]            = fifo_empty;
      stat[STAT_CNT_LSB +: 4]     = cnt_sat;
      bus.IOBUS_IN = (bus.IOBUS_ADDR == STAT_ADDR) ? stat : '0;
   end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx at CLK_DIV=4, FIFO_DEPTH=4.
module tb_iobus_uart_tx;

   localparam int          DIV   = 4;
   localparam logic [31:0] A_TX  = 32'h1100_0040;
   localparam logic [31:0] A_ST  = 32'h1100_0044;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic TXD, TX_BUSY;

   iobus_uart_tx_if bus();

   iobus_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus),
      .TXD     (TXD),
      .TX_BUSY (TX_BUSY)
   );

   always #5 CLK = ~CLK;

   int           n_chk = 0;
   int           n_fail = 0;
   logic [255:0] wave;
   logic [255:0] exp_w;
   int           rec_n;
   logic         rec_on = 1'b0;
   logic [31:0]  st;
   int           bad;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample just after it, optionally record TXD
   task automatic tick();
      @(posedge CLK);
      #1;
      if (rec_on && rec_n < 256) begin
         wave[rec_n] = TXD;
         rec_n++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rec_start();
      wave   = '0;
      rec_n  = 0;
      rec_on = 1'b1;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      bus.IOBUS_ADDR = addr;
      bus.IOBUS_OUT  = data;
      bus.IOBUS_WR   = 1'b1;
      tick();
      bus.IOBUS_WR   = 1'b0;
      bus.IOBUS_ADDR = 32'h0;
      bus.IOBUS_OUT  = 32'h0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] v);
      bus.IOBUS_ADDR = addr;
      #1;
      v = bus.IOBUS_IN;
      bus.IOBUS_ADDR = 32'h0;
   endtask

   // Expected TXD per cycle for one 8N1 frame: start, 8 data LSB first, stop
   function automatic logic [39:0] frame_bits(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 40; i++) begin
         int j;
         j = i / DIV;
         if (j == 0)      f[i] = 1'b0;
         else if (j == 9) f[i] = 1'b1;
         else             f[i] = b[j-1];
      end
      return f;
   endfunction

   task automatic idle_scan(input int n);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (TXD !== 1'b1 || TX_BUSY !== 1'b0) bad++;
      end
   endtask

   initial begin
      bus.IOBUS_ADDR = 32'h0;
      bus.IOBUS_OUT  = 32'h0;
      bus.IOBUS_WR   = 1'b0;

      // Reset then idle
      #1 RST = 1'b0;
      #2;
      chk("rst_txd", 256'(TXD), 256'(1));
      chk("rst_busy", 256'(TX_BUSY), 256'(0));
      run(3);
      RST = 1'b1;
      idle_scan(50);
      chk("idle_bad_cycles", 256'(bad), 256'(0));
      rd(A_ST, st);
      chk("idle_stat", 256'(st), 256'(32'h0000_0008));

      // Single byte 0xA5 with junk in the upper bits
      bus_wr(A_TX, 32'hFFFF_FFA5);
      chk("single_txd_pre", 256'(TXD), 256'(1));
      rd(A_ST, st);
      chk("single_stat", 256'(st), 256'(32'h0000_0014));
      rd(A_TX, st);
      chk("tx_addr_reads_zero", 256'(st), 256'(0));
      rec_start();
      run(40);
      rec_on = 1'b0;
      chk("single_wave", wave, 256'(frame_bits(8'hA5)));
      tick();
      chk("single_busy_done", 256'(TX_BUSY), 256'(0));

      // Back-to-back frames
      bus_wr(A_TX, 32'h55);
      rec_start();
      bus_wr(A_TX, 32'h0F);
      run(79);
      rec_on = 1'b0;
      chk("b2b_wave", wave, 256'({frame_bits(8'h0F), frame_bits(8'h55)}));
      tick();
      chk("b2b_busy_done", 256'(TX_BUSY), 256'(0));

      // Overflow: six writes, first one popped on the next edge, sixth dropped
      bus_wr(A_TX, 32'h11);
      rec_start();
      for (int k = 1; k < 6; k++) bus_wr(A_TX, 32'(8'h11 + k));
      rd(A_ST, st);
      chk("ovf_stat", 256'(st), 256'(32'h0000_0047));
      run(195);
      rec_on = 1'b0;
      exp_w = '0;
      for (int k = 0; k < 5; k++) exp_w[k*40 +: 40] = frame_bits(8'(8'h11 + k));
      chk("ovf_wave", wave, exp_w);
      tick();
      chk("ovf_busy_done", 256'(TX_BUSY), 256'(0));
      run(20);
      rd(A_ST, st);
      chk("ovf_stat_after", 256'(st), 256'(32'h0000_000A));
      bus_wr(A_ST, 32'h2);
      rd(A_ST, st);
      chk("ovf_clear", 256'(st), 256'(32'h0000_0008));

      // Full FIFO plus push on the STOP-end pop edge
      bus_wr(A_TX, 32'hC1);
      rec_start();
      bus_wr(A_TX, 32'hC2);
      bus_wr(A_TX, 32'hC3);
      bus_wr(A_TX, 32'hC4);
      bus_wr(A_TX, 32'hC5);
      run(36);
      rd(A_ST, st);
      chk("full_stat_pre", 256'(st), 256'(32'h0000_0045));
      bus_wr(A_TX, 32'hC6);
      rd(A_ST, st);
      chk("full_stat_post", 256'(st), 256'(32'h0000_0045));
      run(199);
      rec_on = 1'b0;
      exp_w = '0;
      for (int k = 0; k < 6; k++) exp_w[k*40 +: 40] = frame_bits(8'(8'hC1 + k));
      chk("full_wave", wave, exp_w);
      tick();
      chk("full_busy_done", 256'(TX_BUSY), 256'(0));

      // Reset during DATA bit 3 with two bytes queued
      bus_wr(A_TX, 32'hF0);
      bus_wr(A_TX, 32'h81);
      bus_wr(A_TX, 32'h7E);
      run(16);
      chk("midrst_txd_before", 256'(TXD), 256'(0));
      #2 RST = 1'b0;
      #1;
      chk("midrst_txd_async", 256'(TXD), 256'(1));
      chk("midrst_busy_async", 256'(TX_BUSY), 256'(0));
      run(2);
      RST = 1'b1;
      rd(A_ST, st);
      chk("midrst_stat", 256'(st), 256'(32'h0000_0008));
      idle_scan(100);
      chk("midrst_no_frames", 256'(bad), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
